car_nav_ctrl: RTL
=================

Name: car_nav_ctrl

Overview:
Navigation controller that consumes the four debounced obstacle flags (front/left/right/back, 1 = obstacle) from the sensor-conditioning stage. It drives the car's two H-bridge motor channels.
A priority-based FSM selects forward, timed spin-turn, timed reverse or halt. Every change of drive direction passes through a dead-time stop. Motor enables are PWM-modulated by a runtime duty value.

Parameters:
DEAD_T, 50000, cycles all motor lines held low between any two drive states (>=1)
TURN_T, 2000000, cycles a spin-turn lasts (>=1)
REV_T, 4000000, maximum cycles of a reverse manoeuvre (>=1)
PWM_PERIOD, 1000, PWM period in cycles (>=2)
CNT_W, 23, manoeuvre counter width; must hold max(DEAD_T,TURN_T,REV_T)-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; 0 forces IDLE
f  in  1  front obstacle (debounced)
l  in  1  left obstacle
r  in  1  right obstacle
b  in  1  back obstacle
duty  in  10  PWM on-cycles per period
lf  out  1  left motor forward drive
lr  out  1  left motor reverse drive
rf  out  1  right motor forward drive
rr  out  1  right motor reverse drive
state_o  out  3  current FSM state code
busy  out  1  1 while in DEAD, TURN_L, TURN_R or REV

Behaviour:
- Reset: clk is the clock; rst_n is an asynchronous, active-low reset.
- Reset values: state=IDLE(0), all counters 0, lf=lr=rf=rr=0, busy=0.
- State codes: IDLE=0, FWD=1, DEAD=2, TURN_L=3, TURN_R=4, REV=5, HALT=6.
- Decision function dec(f,l,r,b), in priority order:
  - f=0 -> FWD
  - f=1,l=0 -> TURN_L
  - f=1,l=1,r=0 -> TURN_R
  - f=1,l=1,r=1,b=0 -> REV
  - all 1 -> HALT
- en=0 in any state: IDLE on the next edge. Outputs low that same edge. Counters cleared.
- IDLE, en=1: go to DEAD.
- DEAD:
  - The manoeuvre counter starts at 0 on entry.
  - When cnt==DEAD_T-1, go to dec() sampled on that cycle. DEAD lasts exactly DEAD_T cycles.
- FWD: f=1 -> DEAD. Otherwise stay; l/r/b are ignored.
- TURN_L / TURN_R:
  - Lasts exactly TURN_T cycles, then DEAD.
  - Flag changes are ignored; only en can abort.
- REV: leaves to DEAD when cnt==REV_T-1 OR b=1, whichever comes first. If b=1 on the entry cycle, REV lasts 1 cycle.
- HALT: stays while f&l&r&b. Any flag clearing -> DEAD.
- A drive state is never re-entered without a DEAD interval. FWD->DEAD->FWD is legal if f clears during DEAD.
- Drive mapping (p = PWM on):
  - FWD: lf=rf=p
  - TURN_L: lr=rf=p
  - TURN_R: lf=rr=p
  - REV: lr=rr=p
  - IDLE/DEAD/HALT: all 0
- Invariant: lf&lr and rf&rr are never 1.
- Outputs are registered and update on the same edge as state_o.
- PWM:
  - Free-running counter 0..PWM_PERIOD-1; wraps to 0; runs in all states.
  - p = (pwm_cnt < duty).
  - duty=0 -> always off; duty>=PWM_PERIOD -> always on.
  - duty is sampled every cycle; no glitch protection is required.
- busy is registered alongside state.

Decomposition:
- Shared package car_pkg:
  - state codes (3-bit localparams/enum)
  - motor drive pattern constants (4-bit {lf,lr,rf,rr} per state)
  - the dec() priority function
  car_pkg is reused by the display and sim-top blocks.
- Sub-module pwm_gen: parameter PWM_PERIOD; inputs clk, rst_n, duty; output p (combinational compare of the internal counter).
- The FSM and manoeuvre counter stay in car_nav_ctrl.

Test Plan:
Bench parameters: DEAD_T=4, TURN_T=10, REV_T=20, PWM_PERIOD=8, duty=8 unless stated.
1. Reset, en=1, all flags 0 -> DEAD for 4 cycles with outputs 0000, then FWD with lf=rf=1, lr=rr=0, state_o=1.
2. In FWD, pulse f=1 with l=0 -> DEAD 4 cycles, then TURN_L (lr=rf=1) for exactly 10 cycles. Then DEAD, then FWD if f cleared.
3. f=l=r=1, b=0 -> REV (lr=rr=1). Assert b=1 at REV cycle 5 -> DEAD on the next edge. With all flags still 1, dec gives HALT, state_o=6, outputs 0.
4. In HALT, clear r -> DEAD 4 cycles, then TURN_R (lf=rr=1) for 10 cycles.
5. Drop en mid-TURN_L -> IDLE next edge, outputs 0000, busy=0. Re-assert en -> DEAD then decision. Separately, assert rst_n=0 asynchronously mid-REV -> outputs 0 immediately.
6. FWD with duty=3 -> lf/rf high 3 of every 8 cycles. duty=0 -> never high. duty=12 -> constant high. Check lf&lr==0 and rf&rr==0 throughout all tests.

Source files
------------

// File: rtl/car_pkg.sv
// Shared navigation definitions: FSM state codes, motor drive patterns and the
// obstacle priority decision used by the controller, display and sim-top blocks.
package car_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FWD    = 3'd1,
      S_DEAD   = 3'd2,
      S_TURN_L = 3'd3,
      S_TURN_R = 3'd4,
      S_REV    = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   // Drive patterns packed as {lf, lr, rf, rr}
   localparam logic [3:0] DRV_OFF    = 4'b0000;
   localparam logic [3:0] DRV_FWD    = 4'b1010;
   localparam logic [3:0] DRV_TURN_L = 4'b0110;
   localparam logic [3:0] DRV_TURN_R = 4'b1001;
   localparam logic [3:0] DRV_REV    = 4'b0101;

   function automatic state_t dec(input logic f, input logic l,
                                  input logic r, input logic b);
      state_t s;
      if (!f)      s = S_FWD;
      else if (!l) s = S_TURN_L;
      else if (!r) s = S_TURN_R;
      else if (!b) s = S_REV;
      else         s = S_HALT;
      return s;
   endfunction

   function automatic logic [3:0] drive_pat(input state_t s);
      logic [3:0] d;
      case (s)
         S_FWD:    d = DRV_FWD;
         S_TURN_L: d = DRV_TURN_L;
         S_TURN_R: d = DRV_TURN_R;
         S_REV:    d = DRV_REV;
         default:  d = DRV_OFF;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM generator: p is high while the period counter is below duty.
module pwm_gen #(
   parameter int PWM_PERIOD = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] duty,
   output logic       p
);

   localparam int CW = (PWM_PERIOD > 2) ? $clog2(PWM_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(PWM_PERIOD - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             cnt_q <= '0;
      else if (cnt_q == LAST) cnt_q <= '0;
      else                    cnt_q <= cnt_q + 1'b1;
   end

   // duty >= PWM_PERIOD naturally yields a constant-on output
   assign p = (32'(cnt_q) < 32'(duty));

endmodule

// File: rtl/car_nav_ctrl.sv
// Priority navigation FSM driving two H-bridge channels, with a dead-time stop
// between every pair of drive states and PWM-gated motor enables.
module car_nav_ctrl
   import car_pkg::*;
#(
   parameter int DEAD_T     = 50000,
   parameter int TURN_T     = 2000000,
   parameter int REV_T      = 4000000,
   parameter int PWM_PERIOD = 1000,
   parameter int CNT_W      = 23
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       f,
   input  logic       l,
   input  logic       r,
   input  logic       b,
   input  logic [9:0] duty,
   output logic       lf,
   output logic       lr,
   output logic       rf,
   output logic       rr,
   output logic [2:0] state_o,
   output logic       busy
);

   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_T - 1);
   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_T - 1);
   localparam logic [CNT_W-1:0] REV_LAST  = CNT_W'(REV_T - 1);

   logic             p;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       drv_q, drv_d;
   logic             busy_q, busy_d;

   pwm_gen #(.PWM_PERIOD(PWM_PERIOD)) u_pwm (
      .clk   (clk),
      .rst_n (rst_n),
      .duty  (duty),
      .p     (p)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (!en) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_DEAD;
            S_DEAD: begin
               if (cnt_q == DEAD_LAST) state_d = dec(f, l, r, b);
               else                    cnt_d   = cnt_q + 1'b1;
            end
            S_FWD:  if (f) state_d = S_DEAD;
            S_TURN_L, S_TURN_R: begin
               if (cnt_q == TURN_LAST) state_d = S_DEAD;
               else                    cnt_d   = cnt_q + 1'b1;
            end
            S_REV: begin
               if (b || cnt_q == REV_LAST) state_d = S_DEAD;
               else                        cnt_d   = cnt_q + 1'b1;
            end
            S_HALT: if (!(f && l && r && b)) state_d = S_DEAD;
            default: state_d = S_IDLE;
         endcase
      end
      // Outputs are derived from the next state so they change with state_o
      drv_d  = drive_pat(state_d) & {4{p}};
      busy_d = (state_d == S_DEAD) || (state_d == S_TURN_L) ||
               (state_d == S_TURN_R) || (state_d == S_REV);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         drv_q   <= DRV_OFF;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drv_q   <= drv_d;
         busy_q  <= busy_d;
      end
   end

   assign lf      = drv_q[3];
   assign lr      = drv_q[2];
   assign rf      = drv_q[1];
   assign rr      = drv_q[0];
   assign state_o = state_q;
   assign busy    = busy_q;

endmodule
